// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scan_decoder select generator:
// FSM state encoding, mode constants and the dwell-counter width helper.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2; clog2(1) = 0 so a one-cycle dwell still gets a 1-bit counter.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control/select bundle between a peripheral controller (master) and the
// scan_decoder (slave).
interface scan_decoder_if #(
    parameter int SEL_W = 3
);
    logic                  enable;
    logic                  mode;
    logic [SEL_W-1:0]      a;
    logic [2**SEL_W-1:0]   y;
    logic [SEL_W-1:0]      idx;
    logic                  valid;
    logic                  wrap;

    modport master (output enable, mode, a, input y, idx, valid, wrap);
    modport slave  (input enable, mode, a, output y, idx, valid, wrap);
endinterface

// File: rtl/sel_decode.sv
// Combinational index to select-line converter: one-hot (bit idx only) or
// thermometer (bits 0..idx) coding.
module sel_decode #(
    parameter int SEL_W  = 3,
    parameter int THERMO = 0
) (
    input  logic [SEL_W-1:0]    idx_i,
    output logic [2**SEL_W-1:0] y_o
);

    for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_bit
        localparam logic [SEL_W-1:0] K = SEL_W'(gi);
        if (THERMO != 0) begin : g_thermo
            assign y_o[gi] = (K <= idx_i);
        end else begin : g_onehot
            assign y_o[gi] = (K == idx_i);
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered select generator: DIRECT decodes the external index, SCAN sweeps
// every output with a programmable dwell. All outputs come straight from flops.
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W  = 3,
    parameter int DWELL  = 4,
    parameter int THERMO = 0
) (
    input  logic           clk,
    input  logic           reset_n,
    scan_decoder_if.slave  bus
);

    localparam int N_OUT = 2**SEL_W;
    localparam int CNT_W = clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = {SEL_W{1'b1}};

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic [N_OUT-1:0]   y_q;
    logic [N_OUT-1:0]   dec_y;

    // Defaults describe IDLE, so a dropped enable always wins over dwell expiry.
    always_comb begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (bus.enable) begin
            case (bus.mode)
                MODE_DIRECT: begin
                    state_d = DIRECT;
                    idx_d   = bus.a;
                    valid_d = 1'b1;
                end
                MODE_SCAN: begin
                    state_d = SCAN;
                    valid_d = 1'b1;
                    // Entering SCAN keeps the zeroed defaults: sweep restarts at 0.
                    if (state_q == SCAN) begin
                        if (cnt_q == CNT_LAST) begin
                            idx_d  = idx_q + 1'b1;
                            wrap_d = (idx_q == IDX_LAST);
                        end else begin
                            idx_d = idx_q;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Decode the next index so y lands in the same flop stage as idx.
    sel_decode #(
        .SEL_W  (SEL_W),
        .THERMO (THERMO)
    ) u_sel_decode (
        .idx_i (idx_d),
        .y_o   (dec_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            y_q     <= valid_d ? dec_y : '0;
        end
    end

    assign bus.y     = y_q;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder across four parameter sets; stimulus pushes
// expected outputs tagged with their cycle, a negedge monitor pops and compares.
module tb_scan_decoder;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scan_decoder_if #(.SEL_W(3)) if0 ();
    scan_decoder_if #(.SEL_W(2)) if1 ();
    scan_decoder_if #(.SEL_W(3)) if2 ();
    scan_decoder_if #(.SEL_W(1)) if3 ();

    scan_decoder #(.SEL_W(3), .DWELL(4), .THERMO(0)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    scan_decoder #(.SEL_W(2), .DWELL(3), .THERMO(0)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    scan_decoder #(.SEL_W(3), .DWELL(4), .THERMO(1)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));
    scan_decoder #(.SEL_W(1), .DWELL(1), .THERMO(0)) u3 (.clk(clk), .reset_n(reset_n), .bus(if3));

    logic [7:0] act_y   [4];
    logic [2:0] act_idx [4];
    logic       act_v   [4];
    logic       act_w   [4];

    assign act_y[0]   = if0.y;
    assign act_y[1]   = {4'b0, if1.y};
    assign act_y[2]   = if2.y;
    assign act_y[3]   = {6'b0, if3.y};
    assign act_idx[0] = if0.idx;
    assign act_idx[1] = {1'b0, if1.idx};
    assign act_idx[2] = if2.idx;
    assign act_idx[3] = {2'b0, if3.idx};
    assign act_v[0] = if0.valid;
    assign act_v[1] = if1.valid;
    assign act_v[2] = if2.valid;
    assign act_v[3] = if3.valid;
    assign act_w[0] = if0.wrap;
    assign act_w[1] = if1.wrap;
    assign act_w[2] = if2.wrap;
    assign act_w[3] = if3.wrap;

    string tname [10] = '{"reset", "idle", "direct", "scan", "thermo",
                          "interrupt", "scan_w1", "drop", "async_rst", "rescan"};

    typedef struct {
        int         d;
        int         cyc;
        int         tid;
        logic [7:0] y;
        logic [2:0] idx;
        logic       v;
        logic       w;
    } exp_t;

    exp_t sb [$];

    task automatic compare(input int tid, input int d, input logic [7:0] ey,
                           input logic [2:0] ei, input logic ev, input logic ew);
        logic [7:0] ay;
        logic [2:0] ai;
        logic       av;
        logic       aw;
        ay = act_y[d];
        ai = act_idx[d];
        av = act_v[d];
        aw = act_w[d];
        n_checks++;
        if (ay === ey && ai === ei && av === ev && aw === ew) begin
            n_pass++;
            $display("check %s dut%0d cyc%0d: y=%02h idx=%0d valid=%b wrap=%b",
                     tname[tid], d, cyc, ay, ai, av, aw);
        end else begin
            $display("FAIL %s dut%0d cyc%0d: got y=%02h idx=%0d valid=%b wrap=%b, required y=%02h idx=%0d valid=%b wrap=%b",
                     tname[tid], d, cyc, ay, ai, av, aw, ey, ei, ev, ew);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            compare(e.tid, e.d, e.y, e.idx, e.v, e.w);
        end
    end

    task automatic drive(input int d, input logic en, input logic md, input logic [2:0] av);
        case (d)
            0: begin if0.enable = en; if0.mode = md; if0.a = av; end
            1: begin if1.enable = en; if1.mode = md; if1.a = av[1:0]; end
            2: begin if2.enable = en; if2.mode = md; if2.a = av; end
            default: begin if3.enable = en; if3.mode = md; if3.a = av[0]; end
        endcase
    endtask

    // Apply inputs for one edge and register what must appear after that edge.
    task automatic step(input int d, input logic en, input logic md, input logic [2:0] av,
                        input int tid, input logic [7:0] ey, input logic [2:0] ei,
                        input logic ev, input logic ew);
        exp_t e;
        drive(d, en, md, av);
        e = '{d, cyc + 1, tid, ey, ei, ev, ew};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ix;
        reset_n = 1'b0;
        for (int d = 0; d < 4; d++) drive(d, 1'b0, 1'b0, 3'd0);
        drive(0, 1'b1, 1'b0, 3'd5);
        #1;
        compare(0, 0, 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Reset held with enable high, then idle cycles
        step(0, 1'b1, 1'b0, 3'd5, 0, 8'h00, 3'd0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 3'd5, 0, 8'h00, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 3'd5, 1, 8'h00, 3'd0, 1'b0, 1'b0);

        // DIRECT one-hot
        step(0, 1'b1, 1'b0, 3'd0, 2, 8'h01, 3'd0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0, 3'd3, 2, 8'h08, 3'd3, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0, 3'd7, 2, 8'h80, 3'd7, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0, 3'd7, 1, 8'h00, 3'd0, 1'b0, 1'b0);

        // SCAN, SEL_W=2, DWELL=3: full sweep with wrap on the 13th cycle
        for (int i = 0; i < 13; i++) begin
            ix = (i / 3) % 4;
            step(1, 1'b1, 1'b1, 3'd2, 3, 8'(1) << ix, 3'(ix), 1'b1, i == 12);
        end
        step(1, 1'b0, 1'b1, 3'd0, 1, 8'h00, 3'd0, 1'b0, 1'b0);

        // Enable drops on the same edge the dwell of the last index expires
        for (int i = 0; i < 12; i++) begin
            ix = i / 3;
            step(1, 1'b1, 1'b1, 3'd0, 9, 8'(1) << ix, 3'(ix), 1'b1, 1'b0);
        end
        step(1, 1'b0, 1'b1, 3'd0, 7, 8'h00, 3'd0, 1'b0, 1'b0);

        // Thermometer coding
        step(2, 1'b1, 1'b0, 3'd4, 4, 8'h1F, 3'd4, 1'b1, 1'b0);
        step(2, 1'b1, 1'b0, 3'd0, 4, 8'h01, 3'd0, 1'b1, 1'b0);
        step(2, 1'b0, 1'b0, 3'd0, 1, 8'h00, 3'd0, 1'b0, 1'b0);

        // Interrupts: SCAN -> DIRECT at idx 2, back to SCAN restarts at 0
        for (int i = 0; i < 9; i++) begin
            ix = i / 4;
            step(0, 1'b1, 1'b1, 3'd3, 5, 8'(1) << ix, 3'(ix), 1'b1, 1'b0);
        end
        step(0, 1'b1, 1'b0, 3'd6, 5, 8'h40, 3'd6, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b1, 3'd6, 5, 8'h01, 3'd0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1, 3'd6, 5, 8'h02, 3'd1, 1'b1, 1'b0);

        // Asynchronous reset mid-sweep, checked before any clock edge
        @(negedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 3'd0);
        reset_n = 1'b0;
        #1;
        compare(8, 0, 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(0, 1'b0, 1'b0, 3'd0, 1, 8'h00, 3'd0, 1'b0, 1'b0);

        // SEL_W=1, DWELL=1: alternate every cycle, wrap every second cycle
        for (int i = 0; i < 6; i++) begin
            ix = i % 2;
            step(3, 1'b1, 1'b1, 3'd0, 6, 8'(1) << ix, 3'(ix), 1'b1, (i != 0) && (ix == 0));
        end
        step(3, 1'b0, 1'b1, 3'd0, 1, 8'h00, 3'd0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
